// File: rtl/linebuf_ctrl_if.sv
// linebuf_ctrl_if: sequencer outputs towards the line RAMs
// and the 3x3 window datapath.
interface linebuf_ctrl_if #(
  parameter int COL_W = 6,
  parameter int ROW_W = 6
);
  logic             oBusy;
  logic             oWrEn;
  logic [2:0]       oWrSel;
  logic [COL_W-1:0] oWrAddr;
  logic             oRdEn;
  logic [COL_W-1:0] oRdAddr;
  logic [COL_W-1:0] oCol;
  logic [ROW_W-1:0] oRow;
  logic             oWinValid;
  logic             oLineDone;
  logic             oFrameDone;

  modport master (
    output oBusy, oWrEn, oWrSel, oWrAddr,
    output oRdEn, oRdAddr, oCol, oRow,
    output oWinValid, oLineDone, oFrameDone
  );

  modport slave (
    input oBusy, oWrEn, oWrSel, oWrAddr,
    input oRdEn, oRdAddr, oCol, oRow,
    input oWinValid, oLineDone, oFrameDone
  );
endinterface

// File: rtl/linebuf_ctrl.sv
// linebuf_ctrl: raster sequencer for a three-line buffer.
// Steps col/row per pixel tick and emits registered RAM strobes.
module linebuf_ctrl #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int COL_W      = 6,
  parameter int ROW_W      = 6
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEnable,
  input  logic iStart,
  linebuf_ctrl_if.master bus
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [2:0]       sel;

  logic pix;
  logic col_end;
  logic row_end;

  logic             busy_q;
  logic             wr_q;
  logic [2:0]       sel_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             win_q;
  logic             ld_q;
  logic             fd_q;

  logic             busy_n;
  logic             wr_n;
  logic [2:0]       sel_n;
  logic [COL_W-1:0] col_n;
  logic [ROW_W-1:0] row_n;
  logic             win_n;
  logic             ld_n;
  logic             fd_n;

  assign pix     = (state == ACTIVE) && iEnable;
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);

  // State register
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: start only from IDLE, finish on the last pixel
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (iStart) begin
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pix && col_end && row_end) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Raster counters and rotating line select
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      col <= '0;
      row <= '0;
      sel <= 3'b001;
    end else if (state == IDLE) begin
      col <= '0;
      row <= '0;
      sel <= 3'b001;
    end else if (pix) begin
      if (!col_end) begin
        col <= col + COL_W'(1);
      end else begin
        col <= '0;
        if (!row_end) begin
          row <= row + ROW_W'(1);
          sel <= {sel[1:0], sel[2]};
        end
      end
    end
  end

  // Output decode: strobes on a pixel, position fields hold otherwise
  always_comb begin
    busy_n = (state_n != IDLE);
    wr_n   = pix;
    win_n  = pix && (row >= ROW_TWO) && (col >= COL_TWO);
    ld_n   = pix && col_end;
    fd_n   = pix && col_end && row_end;
    sel_n  = sel_q;
    col_n  = col_q;
    row_n  = row_q;
    if (pix) begin
      sel_n = sel;
      col_n = col;
      row_n = row;
    end
  end

  // Output registers
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      busy_q <= 1'b0;
      wr_q   <= 1'b0;
      sel_q  <= 3'b001;
      col_q  <= '0;
      row_q  <= '0;
      win_q  <= 1'b0;
      ld_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      busy_q <= busy_n;
      wr_q   <= wr_n;
      sel_q  <= sel_n;
      col_q  <= col_n;
      row_q  <= row_n;
      win_q  <= win_n;
      ld_q   <= ld_n;
      fd_q   <= fd_n;
    end
  end

  assign bus.oBusy      = busy_q;
  assign bus.oWrEn      = wr_q;
  assign bus.oRdEn      = wr_q;
  assign bus.oWrSel     = sel_q;
  assign bus.oWrAddr    = col_q;
  assign bus.oRdAddr    = col_q;
  assign bus.oCol       = col_q;
  assign bus.oRow       = row_q;
  assign bus.oWinValid  = win_q;
  assign bus.oLineDone  = ld_q;
  assign bus.oFrameDone = fd_q;

endmodule
